ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: ADDR_SIZE, 8, width of RAM address and data bytes.
REQ-002 Parameter: RD_TIMEOUT, 15, maximum cycles spent in WAIT_RD before abort.
REQ-003 Clocking and reset: one clock, clk; reset rst is asynchronous and active-high.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  async active-high reset.
- req_a / req_b  in  1  requester A/B transaction request, held until done.
- wr_a / wr_b  in  1  1 = write, 0 = read.
- addr_a / addr_b  in  8  RAM address.
- wdata_a / wdata_b  in  8  write data.
- gnt_a / gnt_b  out  1  one-cycle grant pulse.
- done_a / done_b  out  1  one-cycle completion pulse.
- err_a / err_b  out  1  one-cycle read-timeout pulse, coincident with done.
- rdata_a / rdata_b  out  8  read data, valid with done and held until the next read to the same port.
- busy  out  1  high whenever the FSM is not IDLE.
- ram_din  out  10  RAM command word, {op[1:0], byte[7:0]}.
- ram_rx_valid  out  1  RAM command strobe.
- ram_dout  in  8  RAM read data.
- ram_tx_valid  in  1  RAM read-data valid.

Function
REQ-005 All outputs SHALL be registered.
REQ-006 The FSM SHALL have the states IDLE, SEND_ADDR, SEND_OP, WAIT_RD and RESP.
REQ-007 IDLE: at clock edge E0 with any req high, the block SHALL select a winner, latch its wr/addr/wdata, and go to SEND_ADDR.
REQ-008 Arbitration SHALL be round-robin:
- single request: that requester wins.
- both requesting: the requester not served last wins.
- after reset: A has priority.
REQ-009 After E0: gnt_x=1 for exactly one cycle; ram_rx_valid=1; ram_din={wr?2'b00:2'b10, addr}.
REQ-010 After E1 (SEND_OP): ram_rx_valid=1; ram_din={2'b01, wdata} for a write, or {2'b11, 8'h00} for a read.
REQ-011 After E2: ram_rx_valid=0.
- write: next state RESP.
- read: next state WAIT_RD with the timeout counter cleared.
REQ-012 WAIT_RD: ram_tx_valid SHALL be sampled only in this state.
- ram_tx_valid high: rdata_x<=ram_dout, go to RESP.
- counter reaches RD_TIMEOUT: rdata_x unchanged, err flag set, go to RESP.
REQ-013 RESP: done_x=1 (and err_x if flagged) for one cycle; last-served pointer updated; next state IDLE.
REQ-014 Latency from E0 to done visible:
- write: 3 cycles (done after E2 edge... RESP registered output after E3 edge is not used; done SHALL be high in the cycle following E2).
- read with a nominal RAM: done high in the cycle following E3.
REQ-015 A requester deasserting req mid-transaction SHALL NOT abort it; the transaction completes and done still pulses.
REQ-016 ram_rx_valid SHALL be high for exactly two consecutive cycles per transaction, never outside SEND_ADDR/SEND_OP.
REQ-017 gnt_x and done_x SHALL never be high for both requesters in the same cycle.
REQ-018 Back-to-back operation: a requester still holding req during its done cycle SHALL be arbitrated normally in the following IDLE cycle, with the other requester winning if it is also requesting.
REQ-019 Minimum spacing between successive transactions: one IDLE cycle.

Reset
REQ-020 rst asserted SHALL immediately force:
- FSM to IDLE.
- all outputs (gnt, done, err, rdata, busy, ram_din, ram_rx_valid) to 0.
- round-robin pointer to A-priority.
- timeout counter to 0.
REQ-021 Reset mid-transaction SHALL drop the transaction without a done pulse; the first edge after rst deassertion SHALL behave as IDLE.

Verification
REQ-022 Write from A (addr 8'h3C, wdata 8'hA5) -> gnt_a after E0; ram_din 10'h03C, then 10'h1A5, each with rx_valid; done_a pulse; no err.
REQ-023 Read from B (addr 8'h3C), RAM model returning A5 one cycle after the 2'b11 command -> ram_din 10'h23C, then 10'h300; done_b with rdata_b=8'hA5.
REQ-024 req_a and req_b asserted together, held for 4 transactions -> grant order A, B, A, B; gnt_x and done_x never overlap.
REQ-025 Read with ram_tx_valid tied low -> done_b and err_b pulse together exactly RD_TIMEOUT cycles after entering WAIT_RD; rdata_b unchanged.
REQ-026 rst pulsed while in SEND_OP -> all outputs 0 immediately; no done pulse; next request is granted from IDLE with A priority.
REQ-027 req_a dropped after its grant -> transaction completes and done_a still pulses.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter giving two requesters access to a byte-wide RAM through a
// two-word command interface; reads abort with err after RD_TIMEOUT idle cycles.
module ram_arbiter #(
  parameter int ADDR_SIZE  = 8,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_a,
  input  logic                 req_b,
  input  logic                 wr_a,
  input  logic                 wr_b,
  input  logic [ADDR_SIZE-1:0] addr_a,
  input  logic [ADDR_SIZE-1:0] addr_b,
  input  logic [ADDR_SIZE-1:0] wdata_a,
  input  logic [ADDR_SIZE-1:0] wdata_b,
  output logic                 gnt_a,
  output logic                 gnt_b,
  output logic                 done_a,
  output logic                 done_b,
  output logic                 err_a,
  output logic                 err_b,
  output logic [ADDR_SIZE-1:0] rdata_a,
  output logic [ADDR_SIZE-1:0] rdata_b,
  output logic                 busy,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid
);

  // state     | meaning
  // IDLE      | waiting for a request, arbitrates on the next edge
  // SEND_ADDR | op/address word on ram_din
  // SEND_OP   | write data or read command word on ram_din
  // WAIT_RD   | waiting for ram_tx_valid, bounded by RD_TIMEOUT
  // RESP      | done (and err) pulse visible, pointer advances on exit
  typedef enum logic [2:0] {IDLE, SEND_ADDR, SEND_OP, WAIT_RD, RESP} state_t;

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  state_t               state;
  logic                 prio_b;
  logic                 cur_b;
  logic                 cur_wr;
  logic [ADDR_SIZE-1:0] cur_wdata;
  logic [CNT_W-1:0]     rd_cnt;

  logic                 pick_b;
  logic                 pick_wr;
  logic [ADDR_SIZE-1:0] pick_addr;
  logic [ADDR_SIZE-1:0] pick_wdata;

  assign pick_b     = req_b & (~req_a | prio_b);
  assign pick_wr    = pick_b ? wr_b : wr_a;
  assign pick_addr  = pick_b ? addr_b : addr_a;
  assign pick_wdata = pick_b ? wdata_b : wdata_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      prio_b       <= 1'b0;
      cur_b        <= 1'b0;
      cur_wr       <= 1'b0;
      cur_wdata    <= '0;
      rd_cnt       <= '0;
      gnt_a        <= 1'b0;
      gnt_b        <= 1'b0;
      done_a       <= 1'b0;
      done_b       <= 1'b0;
      err_a        <= 1'b0;
      err_b        <= 1'b0;
      rdata_a      <= '0;
      rdata_b      <= '0;
      busy         <= 1'b0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
    end else begin
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      done_a <= 1'b0;
      done_b <= 1'b0;
      err_a  <= 1'b0;
      err_b  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            cur_b        <= pick_b;
            cur_wr       <= pick_wr;
            cur_wdata    <= pick_wdata;
            gnt_a        <= ~pick_b;
            gnt_b        <= pick_b;
            ram_rx_valid <= 1'b1;
            ram_din      <= {(pick_wr ? 2'b00 : 2'b10), pick_addr};
            busy         <= 1'b1;
            state        <= SEND_ADDR;
          end
        end
        SEND_ADDR: begin
          ram_din <= cur_wr ? {2'b01, cur_wdata} : {2'b11, {ADDR_SIZE{1'b0}}};
          state   <= SEND_OP;
        end
        SEND_OP: begin
          ram_rx_valid <= 1'b0;
          ram_din      <= '0;
          if (cur_wr) begin
            done_a <= ~cur_b;
            done_b <= cur_b;
            state  <= RESP;
          end else begin
            rd_cnt <= '0;
            state  <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          // a response arriving on the last allowed cycle still wins over the timeout
          if (ram_tx_valid) begin
            if (cur_b) rdata_b <= ram_dout;
            else       rdata_a <= ram_dout;
            done_a <= ~cur_b;
            done_b <= cur_b;
            state  <= RESP;
          end else if (rd_cnt == CNT_LAST) begin
            done_a <= ~cur_b;
            done_b <= cur_b;
            err_a  <= ~cur_b;
            err_b  <= cur_b;
            state  <= RESP;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        RESP: begin
          prio_b <= ~cur_b;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, reset and
// back-to-back sequences, then random transactions against a transaction model.
module tb_ram_arbiter;

  localparam int NO_RESP = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 0, req_b = 0, wr_a = 0, wr_b = 0;
  logic [7:0] addr_a = 0, addr_b = 0, wdata_a = 0, wdata_b = 0;
  logic       gnt_a, gnt_b, done_a, done_b, err_a, err_b, busy, ram_rx_valid;
  logic [7:0] rdata_a, rdata_b;
  logic [9:0] ram_din;
  logic [7:0] ram_dout = 0;
  logic       ram_tx_valid = 0;

  int         ram_lat = NO_RESP;
  logic [7:0] ram_data = 0;
  int         ram_cd = 0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_SIZE(8), .RD_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .wr_a(wr_a), .wr_b(wr_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .err_a(err_a), .err_b(err_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .busy(busy), .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  // RAM: answers a read command ram_lat cycles after it is accepted, garbage data otherwise
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_cd       <= 0;
      ram_tx_valid <= 1'b0;
    end else begin
      ram_tx_valid <= 1'b0;
      ram_dout     <= 8'($urandom);
      if (ram_rx_valid && ram_din[9:8] == 2'b11) begin
        if (ram_lat == 0) begin
          ram_tx_valid <= 1'b1;
          ram_dout     <= ram_data;
        end else if (ram_lat != NO_RESP) begin
          ram_cd <= ram_lat;
        end
      end else if (ram_cd > 0) begin
        ram_cd <= ram_cd - 1;
        if (ram_cd == 1) begin
          ram_tx_valid <= 1'b1;
          ram_dout     <= ram_data;
        end
      end
    end
  end

  typedef struct {
    logic       req_a, req_b, wr_a, wr_b;
    logic [7:0] addr_a, addr_b, wdata_a, wdata_b;
    int         lat;
    logic [7:0] ram_data;
    logic       drop;
    logic       win_b;
    logic [9:0] din0, din1;
    int         done_k;
    logic       err;
    logic [7:0] rd_a, rd_b;
  } vec_t;

  function automatic vec_t mk(input logic ra, rb, wa, wb, input logic [7:0] aa, ab, da, db,
                              input int lat, input logic [7:0] rdat, input logic drop,
                              input logic win_b, input logic [9:0] d0, d1, input int k,
                              input logic err, input logic [7:0] rda, rdb);
    vec_t v;
    v.req_a = ra; v.req_b = rb; v.wr_a = wa; v.wr_b = wb;
    v.addr_a = aa; v.addr_b = ab; v.wdata_a = da; v.wdata_b = db;
    v.lat = lat; v.ram_data = rdat; v.drop = drop;
    v.win_b = win_b; v.din0 = d0; v.din1 = d1; v.done_k = k; v.err = err;
    v.rd_a = rda; v.rd_b = rdb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {gnt_a, gnt_b, done_a, done_b, err_a, err_b, busy, ram_rx_valid,
            ram_din, rdata_a, rdata_b};
  endfunction

  task automatic rst_pulse();
    @(negedge clk);
    req_a = 0; req_b = 0; rst = 1'b1;
    @(negedge clk);
    chk("reset_outputs", all_outs(), 64'h0);
    rst = 1'b0;
  endtask

  // Edge k=0 is the arbitration edge; outputs are sampled on the negedge after edge k.
  task automatic run_txn(input vec_t v);
    int  rxcnt;
    bit  seen;
    @(negedge clk);
    req_a = v.req_a; req_b = v.req_b; wr_a = v.wr_a; wr_b = v.wr_b;
    addr_a = v.addr_a; addr_b = v.addr_b; wdata_a = v.wdata_a; wdata_b = v.wdata_b;
    ram_lat = v.lat; ram_data = v.ram_data;
    rxcnt = 0; seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ram_rx_valid) rxcnt++;
      if (k == 0) begin
        chk("grant", {gnt_a, gnt_b}, v.win_b ? 2'b01 : 2'b10);
        chk("din_addr", {ram_rx_valid, ram_din}, {1'b1, v.din0});
        chk("busy_hi", busy, 1'b1);
        if (v.drop) begin
          if (v.win_b) req_b = 0;
          else         req_a = 0;
        end
      end
      if (k == 1) begin
        chk("grant_1cyc", {gnt_a, gnt_b}, 2'b00);
        chk("din_op", {ram_rx_valid, ram_din}, {1'b1, v.din1});
      end
      if (done_a || done_b) begin
        chk("done_lat", k, v.done_k);
        chk("done_who", {done_a, done_b}, v.win_b ? 2'b01 : 2'b10);
        chk("err", {err_a, err_b}, v.err ? (v.win_b ? 2'b01 : 2'b10) : 2'b00);
        chk("rdata", {rdata_a, rdata_b}, {v.rd_a, v.rd_b});
        seen = 1;
        req_a = 0; req_b = 0;
        break;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    chk("rx_valid_cycles", rxcnt, 2);
    @(negedge clk);
    chk("busy_lo", busy, 1'b0);
    for (int w = 0; w < 30 && ram_cd > 0; w++) @(negedge clk);
  endtask

  vec_t       tbl[8];
  logic       order[4];
  int         n_g, n_d, seen_done;
  logic       m_last_b;
  logic [7:0] m_rd[2];

  initial begin
    tbl[0] = mk(1,0,1,0, 8'h3C,8'h00,8'hA5,8'h00, NO_RESP,8'h00,1, 0,10'h03C,10'h1A5, 2,0, 8'h00,8'h00);
    tbl[1] = mk(0,1,0,0, 8'h00,8'h3C,8'h00,8'h00, 0,8'hA5,0,       1,10'h23C,10'h300, 3,0, 8'h00,8'hA5);
    tbl[2] = mk(1,1,1,1, 8'h10,8'h20,8'h55,8'h66, NO_RESP,8'h00,0, 0,10'h010,10'h155, 2,0, 8'h00,8'hA5);
    tbl[3] = mk(1,1,0,0, 8'h40,8'h41,8'h00,8'h00, 3,8'h7E,0,       1,10'h241,10'h300, 6,0, 8'h00,8'h7E);
    tbl[4] = mk(0,1,0,0, 8'h00,8'h42,8'h00,8'h00, NO_RESP,8'h11,0, 1,10'h242,10'h300, 17,1, 8'h00,8'h7E);
    tbl[5] = mk(1,0,0,0, 8'h50,8'h00,8'h00,8'h00, 14,8'hC3,1,      0,10'h250,10'h300, 17,0, 8'hC3,8'h7E);
    tbl[6] = mk(1,0,0,0, 8'h51,8'h00,8'h00,8'h00, 15,8'h99,0,      0,10'h251,10'h300, 17,1, 8'hC3,8'h7E);
    tbl[7] = mk(1,1,1,1, 8'h00,8'hFF,8'h00,8'h00, NO_RESP,8'h00,0, 1,10'h0FF,10'h100, 2,0, 8'hC3,8'h7E);

    repeat (2) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'h0);
    rst = 1'b0;

    foreach (tbl[i]) run_txn(tbl[i]);

    // both requesters held: grants must alternate starting from A
    rst_pulse();
    @(negedge clk);
    req_a = 1; req_b = 1; wr_a = 1; wr_b = 1; ram_lat = NO_RESP;
    n_g = 0; n_d = 0;
    for (int c = 0; c < 100 && n_d < 4; c++) begin
      @(negedge clk);
      if (gnt_a || gnt_b) begin
        chk("gnt_overlap", gnt_a & gnt_b, 1'b0);
        if (n_g < 4) order[n_g] = gnt_b;
        n_g++;
      end
      if (done_a || done_b) begin
        chk("done_overlap", done_a & done_b, 1'b0);
        n_d++;
      end
    end
    req_a = 0; req_b = 0;
    chk("b2b_done_count", n_d, 4);
    chk("b2b_grant_count", n_g, 4);
    for (int i = 0; i < 4; i++) chk("b2b_order", order[i], (i % 2 == 1));
    repeat (2) @(negedge clk);

    // serve A so B would have priority, then reset B's read while in SEND_OP
    run_txn(mk(1,0,1,0, 8'h11,8'h00,8'h22,8'h00, NO_RESP,8'h00,0, 0,10'h011,10'h122, 2,0, 8'h00,8'h00));
    @(negedge clk);
    req_b = 1; wr_b = 0; addr_b = 8'h77; ram_lat = 0; ram_data = 8'h5A;
    @(negedge clk);
    chk("rst_seq_grant", gnt_b, 1'b1);
    @(negedge clk);
    chk("rst_seq_sendop", ram_din, 10'h300);
    rst = 1'b1; req_b = 0;
    #1;
    chk("rst_async_outs", all_outs(), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_a || done_b || ram_rx_valid) seen_done++;
    end
    chk("rst_no_done", seen_done, 0);
    run_txn(mk(1,1,1,1, 8'h01,8'h02,8'h03,8'h04, NO_RESP,8'h00,0, 0,10'h001,10'h103, 2,0, 8'h00,8'h00));

    // random transactions against a transaction-level model
    rst_pulse();
    m_last_b = 1'b1;
    m_rd[0] = 8'h00; m_rd[1] = 8'h00;
    for (int t = 0; t < 40; t++) begin
      vec_t v;
      int   w;
      logic wr;
      logic [7:0] ad, wd;
      v.req_a = 1'($urandom); v.req_b = 1'($urandom);
      if (!v.req_a && !v.req_b) v.req_a = 1;
      v.wr_a = 1'($urandom); v.wr_b = 1'($urandom);
      v.addr_a = 8'($urandom); v.addr_b = 8'($urandom);
      v.wdata_a = 8'($urandom); v.wdata_b = 8'($urandom);
      v.lat = $urandom_range(0, 20);
      v.ram_data = 8'($urandom);
      v.drop = 1'($urandom);
      v.win_b = v.req_b && (!v.req_a || !m_last_b);
      w  = v.win_b ? 1 : 0;
      wr = v.win_b ? v.wr_b : v.wr_a;
      ad = v.win_b ? v.addr_b : v.addr_a;
      wd = v.win_b ? v.wdata_b : v.wdata_a;
      v.din0 = {(wr ? 2'b00 : 2'b10), ad};
      v.din1 = wr ? {2'b01, wd} : 10'h300;
      v.done_k = wr ? 2 : (v.lat < 15 ? 3 + v.lat : 17);
      v.err = !wr && v.lat >= 15;
      if (!wr && v.lat < 15) m_rd[w] = v.ram_data;
      v.rd_a = m_rd[0]; v.rd_b = m_rd[1];
      m_last_b = v.win_b;
      run_txn(v);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
